// File: rtl/mb_pkg.sv
// Shared definitions for the MB data slice: source-select encoding and the
// per-group odd-parity helper used for both MB and memory-bus parity.
package mb_pkg;

  typedef enum logic [1:0] {
    MB_SRC_CACHE = 2'd0,
    MB_SRC_MEM   = 2'd1,
    MB_SRC_AR    = 2'd2,
    MB_SRC_CHB   = 2'd3
  } mb_src_e;

  localparam int MB_PAR_GRP = 6;
  // Widest slice the helper covers; narrower callers zero-extend and keep the low groups.
  localparam int MB_MAX_W   = 72;
  localparam int MB_MAX_GRP = MB_MAX_W / MB_PAR_GRP;

  function automatic logic [MB_MAX_GRP-1:0] mb_odd_par(input logic [MB_MAX_W-1:0] d);
    logic [MB_MAX_GRP-1:0] p;
    for (int g = 0; g < MB_MAX_GRP; g++) begin
      p[g] = ~^d[g*MB_PAR_GRP +: MB_PAR_GRP];
    end
    return p;
  endfunction

endpackage

// File: rtl/mb_ch_buf.sv
// Channel buffer for the MB slice: DEPTH-entry storage drained either FIFO
// (forward) or LIFO (reverse), with occupancy count and full/empty flags.
module mb_ch_buf
  import mb_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic                     rd_i,
  input  logic                     reverse_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         rdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d, wp_m1, waddr;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wp_m1   = wp_q - 1'b1;

  // Forward mode frees the head slot when full; reverse pops the newest slot, so the push is dropped.
  assign do_push = wr_i && (!full || (rd_i && !reverse_i));
  assign do_pop  = rd_i && !empty;

  // A reverse push+pop overwrites the popped top-of-stack slot in place.
  assign waddr   = (reverse_i && do_pop) ? wp_m1 : wp_q;
  assign rdata_o = reverse_i ? mem_q[wp_m1] : mem_q[rp_q];

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (reverse_i) begin
      if (do_pop && !do_push)      wp_d = wp_m1;
      else if (do_push && !do_pop) wp_d = wp_q + 1'b1;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[waddr] <= wdata_i;
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;

endmodule

// File: rtl/mb_slice_buf.sv
// Parametrised MB data slice: word registers, channel buffer, parity and CBUS drive.
// Define MB_PARITY_CHECK_EN to add the sticky memory-bus parity checker.
module mb_slice_buf
  import mb_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int NWORDS = 4,
  parameter int DEPTH  = 16
) (
  input  logic                        clk_h,
  input  logic                        reset_h,
  input  logic [WIDTH-1:0]            cache_data_h,
  input  logic [WIDTH-1:0]            mem_data_in_h,
`ifdef MB_PARITY_CHECK_EN
  input  logic [WIDTH/6-1:0]          mem_par_h,
  output logic                        mem_par_err_h,
`endif
  input  logic [WIDTH-1:0]            ar_h,
  input  logic [1:0]                  mb_in_sel_h,
  input  logic                        mb_load_h,
  input  logic [$clog2(NWORDS)-1:0]   mb_word_h,
  input  logic [NWORDS-1:0]           mb_hold_h,
  input  logic [$clog2(NWORDS)-1:0]   mb_rd_word_h,
  output logic [WIDTH-1:0]            mb_h,
  output logic [WIDTH/6-1:0]          mb_par_odd_h,
  input  logic                        chb_wr_h,
  input  logic                        chb_rd_h,
  input  logic                        ch_reverse_h,
  output logic                        chb_full_h,
  output logic                        chb_empty_h,
  output logic [$clog2(DEPTH):0]      chb_count_h,
  output logic [WIDTH-1:0]            chb_data_h,
  output logic [WIDTH-1:0]            mem_to_cache_h,
  input  logic                        cbus_out_hold_h,
  output logic [WIDTH-1:0]            cbus_te_h
);

  localparam int NG = WIDTH / MB_PAR_GRP;

  mb_src_e                 src;
  logic [WIDTH-1:0]        mux_d;
  logic [WIDTH-1:0]        word_q [NWORDS];
  logic [WIDTH-1:0]        mb_q, cbus_q, m2c_q;
  logic [NG-1:0]           par_q, par_d;
  logic [MB_MAX_GRP-1:0]   par_full;
  logic                    unused_par_hi;

  assign src = mb_src_e'(mb_in_sel_h);

  always_comb begin
    mux_d = cache_data_h;
    case (src)
      MB_SRC_CACHE: mux_d = cache_data_h;
      MB_SRC_MEM:   mux_d = mem_data_in_h;
      MB_SRC_AR:    mux_d = ar_h;
      MB_SRC_CHB:   mux_d = chb_data_h;
      default:      mux_d = cache_data_h;
    endcase
  end

  // Parity is taken from the same word that feeds mb_q so both register together.
  assign par_full      = mb_odd_par(MB_MAX_W'(word_q[mb_rd_word_h]));
  assign par_d         = par_full[NG-1:0];
  assign unused_par_hi = ^par_full;

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      for (int i = 0; i < NWORDS; i++) word_q[i] <= '0;
      mb_q   <= '0;
      par_q  <= '1;
      cbus_q <= '0;
      m2c_q  <= '0;
    end else begin
      if (mb_load_h && !mb_hold_h[mb_word_h]) word_q[mb_word_h] <= mux_d;
      mb_q  <= word_q[mb_rd_word_h];
      par_q <= par_d;
      if (!cbus_out_hold_h) cbus_q <= mb_q;
      m2c_q <= mem_data_in_h;
    end
  end

  mb_ch_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ch_buf (
    .clk_i     (clk_h),
    .rst_i     (reset_h),
    .wr_i      (chb_wr_h),
    .rd_i      (chb_rd_h),
    .reverse_i (ch_reverse_h),
    .wdata_i   (mem_data_in_h),
    .full_o    (chb_full_h),
    .empty_o   (chb_empty_h),
    .count_o   (chb_count_h),
    .rdata_o   (chb_data_h)
  );

`ifdef MB_PARITY_CHECK_EN
  logic [MB_MAX_GRP-1:0] mem_par_full;
  logic                  unused_mem_par_hi;
  logic                  par_chk_en;
  logic                  par_err_q;

  assign mem_par_full      = mb_odd_par(MB_MAX_W'(mem_data_in_h));
  assign unused_mem_par_hi = ^mem_par_full;
  assign par_chk_en        = chb_wr_h || (mb_load_h && src == MB_SRC_MEM);

  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      par_err_q <= 1'b0;
    end else if (par_chk_en && (mem_par_full[NG-1:0] != mem_par_h)) begin
      par_err_q <= 1'b1;
    end
  end

  assign mem_par_err_h = par_err_q;
`endif

  assign mb_h           = mb_q;
  assign mb_par_odd_h   = par_q;
  assign cbus_te_h      = cbus_q;
  assign mem_to_cache_h = m2c_q;

endmodule

// File: tb/tb_mb_slice_buf.sv
// Self-checking bench for mb_slice_buf: MB load/hold/read, parity, CBUS hold,
// and the channel buffer against a queue model in both drain orders.
module tb_mb_slice_buf;
  import mb_pkg::*;

  localparam int WIDTH  = 12;
  localparam int NWORDS = 4;
  localparam int DEPTH  = 16;

  logic                 clk_h = 1'b0;
  logic                 reset_h;
  logic [WIDTH-1:0]     cache_data_h, mem_data_in_h, ar_h;
  logic [1:0]           mb_in_sel_h;
  logic                 mb_load_h;
  logic [1:0]           mb_word_h, mb_rd_word_h;
  logic [NWORDS-1:0]    mb_hold_h;
  logic [WIDTH-1:0]     mb_h;
  logic [1:0]           mb_par_odd_h;
  logic                 chb_wr_h, chb_rd_h, ch_reverse_h;
  logic                 chb_full_h, chb_empty_h;
  logic [4:0]           chb_count_h;
  logic [WIDTH-1:0]     chb_data_h, mem_to_cache_h, cbus_te_h;
  logic                 cbus_out_hold_h;
`ifdef MB_PARITY_CHECK_EN
  logic [1:0]            mem_par_h;
  logic                  mem_par_err_h;
  logic [MB_MAX_GRP-1:0] tb_par_full;
  assign tb_par_full = mb_odd_par(MB_MAX_W'(mem_data_in_h));
  assign mem_par_h   = tb_par_full[1:0];
`endif

  mb_slice_buf #(.WIDTH(WIDTH), .NWORDS(NWORDS), .DEPTH(DEPTH)) dut (
    .clk_h           (clk_h),
    .reset_h         (reset_h),
    .cache_data_h    (cache_data_h),
    .mem_data_in_h   (mem_data_in_h),
`ifdef MB_PARITY_CHECK_EN
    .mem_par_h       (mem_par_h),
    .mem_par_err_h   (mem_par_err_h),
`endif
    .ar_h            (ar_h),
    .mb_in_sel_h     (mb_in_sel_h),
    .mb_load_h       (mb_load_h),
    .mb_word_h       (mb_word_h),
    .mb_hold_h       (mb_hold_h),
    .mb_rd_word_h    (mb_rd_word_h),
    .mb_h            (mb_h),
    .mb_par_odd_h    (mb_par_odd_h),
    .chb_wr_h        (chb_wr_h),
    .chb_rd_h        (chb_rd_h),
    .ch_reverse_h    (ch_reverse_h),
    .chb_full_h      (chb_full_h),
    .chb_empty_h     (chb_empty_h),
    .chb_count_h     (chb_count_h),
    .chb_data_h      (chb_data_h),
    .mem_to_cache_h  (mem_to_cache_h),
    .cbus_out_hold_h (cbus_out_hold_h),
    .cbus_te_h       (cbus_te_h)
  );

  always #5 clk_h = ~clk_h;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_h);
    #1;
  endtask

  // One channel-buffer cycle: model decides what the DUT should accept, checks
  // popped data before the edge and occupancy after it.
  task automatic chb_op(input bit wr, input bit rd, input logic [WIDTH-1:0] v, input string tag);
    bit m_full, m_empty, m_push, m_pop;
    logic [WIDTH-1:0] exp;
    m_full  = (sb.size() == DEPTH);
    m_empty = (sb.size() == 0);
    m_pop   = rd && !m_empty;
    m_push  = wr && (!m_full || (rd && !ch_reverse_h));
    mem_data_in_h = v;
    chb_wr_h      = wr;
    chb_rd_h      = rd;
    #1;
    if (m_pop) begin
      if (ch_reverse_h) exp = sb.pop_back();
      else              exp = sb.pop_front();
      chk({tag, "_data"}, 32'(chb_data_h), 32'(exp));
    end
    if (m_push) sb.push_back(v);
    tick;
    chb_wr_h = 1'b0;
    chb_rd_h = 1'b0;
    chk({tag, "_cnt"}, 32'(chb_count_h), 32'(sb.size()));
  endtask

  initial begin
    reset_h = 1'b1;
    cache_data_h = '0; mem_data_in_h = '0; ar_h = '0;
    mb_in_sel_h = 2'd0; mb_load_h = 1'b0; mb_word_h = '0; mb_rd_word_h = '0;
    mb_hold_h = '0; chb_wr_h = 1'b0; chb_rd_h = 1'b0; ch_reverse_h = 1'b0;
    cbus_out_hold_h = 1'b0;
    repeat (2) tick;
    reset_h = 1'b0;

    chk("rst_count", 32'(chb_count_h), 32'd0);
    chk("rst_empty", 32'(chb_empty_h), 32'd1);
    chk("rst_full",  32'(chb_full_h),  32'd0);
    chk("rst_mb",    32'(mb_h),        32'd0);
    chk("rst_par",   32'(mb_par_odd_h), 32'd3);
    chk("rst_cbus",  32'(cbus_te_h),   32'd0);
    chk("rst_m2c",   32'(mem_to_cache_h), 32'd0);

    // reset landing in the middle of a push burst
    chb_op(1'b1, 1'b0, 12'h011, "pre_a");
    chb_op(1'b1, 1'b0, 12'h022, "pre_b");
    mem_data_in_h = 12'h033;
    chb_wr_h = 1'b1;
    #2;
    reset_h = 1'b1;
    #1;
    chk("midrst_count", 32'(chb_count_h), 32'd0);
    chk("midrst_empty", 32'(chb_empty_h), 32'd1);
    chk("midrst_mb",    32'(mb_h),        32'd0);
    chk("midrst_par",   32'(mb_par_odd_h), 32'd3);
    sb.delete();
    tick;
    chb_wr_h = 1'b0;
    reset_h  = 1'b0;
    tick;

    // hold blocks the load; same-cycle load+read returns the old word
    ar_h = 12'o7777; mb_in_sel_h = 2'd2; mb_word_h = 2'd2; mb_rd_word_h = 2'd2;
    mb_hold_h = 4'b0100; mb_load_h = 1'b1;
    tick;
    mb_load_h = 1'b0; mb_hold_h = 4'b0000;
    tick;
    chk("hold_blocked", 32'(mb_h), 32'd0);
    mb_load_h = 1'b1;
    tick;
    mb_load_h = 1'b0;
    chk("same_cyc_old", 32'(mb_h), 32'd0);
    tick;
    chk("hold_rel_mb",  32'(mb_h), 32'o7777);
    chk("hold_rel_par", 32'(mb_par_odd_h), 32'd3);

    // memory source load and mem-to-cache latency
    mem_data_in_h = 12'o4321; mb_in_sel_h = 2'd1; mb_word_h = 2'd0; mb_load_h = 1'b1;
    tick;
    mb_load_h = 1'b0;
    chk("m2c", 32'(mem_to_cache_h), 32'o4321);
    mb_rd_word_h = 2'd0;
    tick;
    chk("mem_mb",  32'(mb_h), 32'o4321);
    chk("mem_par", 32'(mb_par_odd_h), 32'd1);

    // cache source load
    cache_data_h = 12'o5252; mb_in_sel_h = 2'd0; mb_word_h = 2'd1; mb_load_h = 1'b1;
    tick;
    mb_load_h = 1'b0; mb_rd_word_h = 2'd1;
    tick;
    chk("cache_mb",  32'(mb_h), 32'o5252);
    chk("cache_par", 32'(mb_par_odd_h), 32'd0);
    chk("word2_kept", 32'(dut.word_q[2]), 32'o7777);

    // forward FIFO: fill, overflow, full+push+pop, drain, empty pop
    ch_reverse_h = 1'b0;
    for (int i = 1; i <= DEPTH; i++) chb_op(1'b1, 1'b0, 12'(i), "fifo_push");
    chk("fifo_full", 32'(chb_full_h), 32'd1);
    chb_op(1'b1, 1'b0, 12'd17, "fifo_ovf");
    chb_op(1'b1, 1'b1, 12'd99, "sim_full_fwd");
    chk("sim_full_fwd_full", 32'(chb_full_h), 32'd1);
    for (int i = 0; i < DEPTH; i++) chb_op(1'b0, 1'b1, '0, "fifo_pop");
    chk("fifo_empty", 32'(chb_empty_h), 32'd1);
    chb_op(1'b0, 1'b1, '0, "pop_empty");
    chb_op(1'b1, 1'b1, 12'h0AB, "sim_empty");
    chb_op(1'b0, 1'b1, '0, "sim_empty_pop");

    // reverse drain
    chb_op(1'b1, 1'b0, 12'd5, "rev_push");
    chb_op(1'b1, 1'b0, 12'd6, "rev_push");
    chb_op(1'b1, 1'b0, 12'd7, "rev_push");
    ch_reverse_h = 1'b1;
    for (int i = 0; i < 3; i++) chb_op(1'b0, 1'b1, '0, "rev_pop");
    chk("rev_empty", 32'(chb_empty_h), 32'd1);

    // reverse: mid-level push+pop, then full push+pop drops the push
    chb_op(1'b1, 1'b0, 12'd8, "rev_mid");
    chb_op(1'b1, 1'b1, 12'd9, "rev_mid_both");
    chb_op(1'b0, 1'b1, '0, "rev_mid_pop");
    for (int i = 1; i <= DEPTH; i++) chb_op(1'b1, 1'b0, 12'(i + 32), "rev_fill");
    chb_op(1'b1, 1'b1, 12'd55, "sim_full_rev");
    chk("sim_full_rev_full", 32'(chb_full_h), 32'd0);
    for (int i = 1; i < DEPTH; i++) chb_op(1'b0, 1'b1, '0, "rev_drain");
    chk("rev_drain_empty", 32'(chb_empty_h), 32'd1);

    // channel-buffer source load with a same-cycle pop
    ch_reverse_h = 1'b0;
    chb_op(1'b1, 1'b0, 12'h02A, "chb_src_push");
    mb_in_sel_h = 2'd3; mb_word_h = 2'd1; mb_load_h = 1'b1;
    chb_op(1'b0, 1'b1, '0, "chb_src_pop");
    mb_load_h = 1'b0;
    mb_rd_word_h = 2'd1;
    tick;
    chk("chb_src_mb", 32'(mb_h), 32'h02A);

    // CBUS hold
    mb_rd_word_h = 2'd3;
    tick;
    tick;
    chk("cbus_pre", 32'(cbus_te_h), 32'd0);
    cbus_out_hold_h = 1'b1;
    ar_h = 12'o1234; mb_in_sel_h = 2'd2; mb_word_h = 2'd3; mb_load_h = 1'b1;
    tick;
    mb_load_h = 1'b0;
    tick;
    chk("cbus_mb",   32'(mb_h), 32'o1234);
    chk("cbus_par",  32'(mb_par_odd_h), 32'd2);
    tick;
    chk("cbus_held", 32'(cbus_te_h), 32'd0);
    cbus_out_hold_h = 1'b0;
    tick;
    chk("cbus_rel",  32'(cbus_te_h), 32'o1234);

`ifdef MB_PARITY_CHECK_EN
    chk("par_err_clean", 32'(mem_par_err_h), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mb_slice_buf.md
Name: mb_slice_buf

Overview:
- Parametrised memory-buffer (MB) data slice, successor to the fixed 12-bit MB board slice.
- Holds NWORDS MB word registers loaded from a selectable source: cache data, memory data in, AR, or the channel buffer read port.
- Contains a DEPTH-entry channel buffer FIFO that supports forward and reverse drain order.
- Generates registered odd parity per 6-bit group, drives the CBUS transmit data and the mem-to-cache path.

Parameters:
- WIDTH, 12, data bits in this slice; must be a multiple of 6.
- NWORDS, 4, number of MB word registers (quad-word transfer).
- DEPTH, 16, channel buffer entries; power of two, at least 2.

Ports:
- clk_h  in  1  slice clock; all state updates on rising edge.
- reset_h  in  1  asynchronous, active-high reset.
- cache_data_h  in  WIDTH  cache data source.
- mem_data_in_h  in  WIDTH  memory bus data source.
- ar_h  in  WIDTH  AR source.
- mb_in_sel_h  in  2  source select: 0 cache, 1 mem, 2 AR, 3 channel buffer.
- mb_load_h  in  1  load strobe for the MB word registers.
- mb_word_h  in  $clog2(NWORDS)  target word index.
- mb_hold_h  in  NWORDS  per-word hold; a set bit blocks that word's load.
- mb_rd_word_h  in  $clog2(NWORDS)  read word index.
- mb_h  out  WIDTH  selected MB word, registered.
- mb_par_odd_h  out  WIDTH/6  odd parity per 6-bit group of mb_h.
- chb_wr_h  in  1  push mem_data_in_h into the channel buffer.
- chb_rd_h  in  1  pop from the channel buffer.
- ch_reverse_h  in  1  reverse drain order (LIFO).
- chb_full_h  out  1  buffer full.
- chb_empty_h  out  1  buffer empty.
- chb_count_h  out  $clog2(DEPTH)+1  occupancy.
- chb_data_h  out  WIDTH  head entry (combinational from storage).
- mem_to_cache_h  out  WIDTH  registered mem_data_in_h, 1-cycle latency.
- cbus_out_hold_h  in  1  freeze cbus_te_h.
- cbus_te_h  out  WIDTH  CBUS transmit data, equal to mb_h unless held.

Behaviour:
- Reset values: all MB words, mb_h, cbus_te_h, mem_to_cache_h, pointers and count are 0. chb_empty_h is 1 and chb_full_h is 0. mb_par_odd_h is all 1s (odd parity of zero). Reset is honoured mid-transfer and discards buffer contents.
- MB load: on mb_load_h, word[mb_word_h] is written with the mux output unless mb_hold_h[mb_word_h] is set. Other words are never touched.
- mb_h: registered, equal to word[mb_rd_word_h] on the previous edge. A same-cycle load and read of the same word returns the old value; the new value appears one cycle later.
- Parity: each group bit is the XNOR-reduce of its 6 data bits, computed from the same registered value as mb_h so the two are always coherent.
- Channel buffer forward mode: FIFO with write pointer wp and read pointer rp, both modulo DEPTH.
- Channel buffer reverse mode: pop takes entry wp-1 and decrements wp; rp is unchanged.
- Push when full: ignored, no state change.
- Pop when empty: ignored; chb_data_h is undefined-but-stable (last storage read).
- Simultaneous push and pop, not full and not empty: both performed and count is unchanged.
- Simultaneous push and pop when empty: push only.
- Simultaneous push and pop when full, forward mode: both performed.
- Simultaneous push and pop when full, reverse mode: pop only.
- mux source 3 uses chb_data_h as sampled that cycle; pop timing is independent of the load.
- Toggling ch_reverse_h takes effect on the next pop with no pointer adjustment.
- CBUS: cbus_te_h <= mb_h each cycle unless cbus_out_hold_h is set, in which case it keeps its value.

Optional Feature:
- Macro: MB_PARITY_CHECK_EN.
- Defined: adds input mem_par_h [WIDTH/6] and output mem_par_err_h [1]. Odd parity of mem_data_in_h is checked each cycle chb_wr_h or mb_load_h with source 1 is active. A mismatch sets mem_par_err_h, which is sticky until reset_h.
- Undefined: neither port exists and there is no check logic.

Decomposition:
- Package mb_pkg holds the mb_src_e enum (MB_SRC_CACHE, MB_SRC_MEM, MB_SRC_AR, MB_SRC_CHB) and the parity group size constant MB_PAR_GRP=6.
- Package mb_pkg also holds the function mb_odd_par(WIDTH vector) returning the group parity vector.
- One sub-module, mb_ch_buf, contains the FIFO/LIFO storage, pointers, count and flags.

Test Plan:
- Reset: assert reset_h mid-push sequence -> count 0, empty 1, mb_h 0, mb_par_odd_h all 1s.
- Hold: load AR=12'o7777 to word 2 with mb_hold_h=4'b0100, then with 0 -> first load leaves word 2 at 0; second gives mb_h=12'o7777 one cycle after the read select, parity 2'b11 (12 ones, groups even -> odd bit 1).
- FIFO: push 1..16 (DEPTH=16) -> full after 16; 17th push ignored; pops return 1..16 in order, then empty.
- Reverse: push 5,6,7, set ch_reverse_h, pop three -> 7,6,5, then empty.
- Simultaneous: at full, forward, push 99 and pop -> pops 1, count stays 16; at empty, push and pop together -> count 1.
- CBUS hold: with cbus_out_hold_h=1, change mb_h from 0 to 12'o1234 -> cbus_te_h stays 0; release -> 12'o1234 next cycle.
